video_decim2bram: RTL and testbench

- Parametrised successor of the pixel-to-BRAM capture stage in the TX video path.
- Takes a DVI/HDMI-decoded pixel stream (sync, vde, RGB) in the pixel clock domain and decimates it independently in three dimensions: horizontally by H_DECIM, vertically by V_DECIM, temporally by F_DECIM.
- Writes the result as a linear raster into a frame BRAM that the packetiser reads.
- Adds per-channel horizontal averaging, configurable sync polarity, frame-done/error pulses and an explicit capture state machine.

---
 rtl/video_decim2bram.sv | 215 +++++++++++++++++++++
 tb/tb_video_decim2bram.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/video_decim2bram.sv
// video_decim2bram
// Captures a decoded pixel stream into a frame BRAM as a linear raster.
// The stream is decimated horizontally (H_DECIM), vertically (V_DECIM) and
// temporally (F_DECIM). Each horizontal group either keeps its first pixel or
// is averaged per 8-bit channel.
//
// Ports
//   pclk           pixel clock; all logic runs on it
//   rst            synchronous active-high reset
//   i_hsync        horizontal sync (no functional effect)
//   i_vsync        vertical sync; polarity set by SYNC_ACTIVE_LOW
//   i_vde          video data enable, high on active pixels
//   i_data         pixel; channel k occupies bits [8k+7:8k]
//   o_we/o_addr/o_data  BRAM write port, one strobe per output pixel
//   o_start_frame  pulse: a captured frame begins
//   o_frame_done   pulse together with the write of the last address
//   o_frame_err    pulse: a captured frame was cut short by a new frame
module video_decim2bram #(
  parameter int PIX_W           = 24,
  parameter int ACTIVE_COLS     = 320,
  parameter int ACTIVE_ROWS     = 180,
  parameter int H_DECIM         = 4,
  parameter int V_DECIM         = 4,
  parameter int F_DECIM         = 3,
  parameter int ADDR_W          = 16,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int AVG_MODE        = 0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_vde,
  input  logic [PIX_W-1:0]  i_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [PIX_W-1:0]  o_data,
  output logic              o_start_frame,
  output logic              o_frame_done,
  output logic              o_frame_err
);

  localparam int NCH   = PIX_W / 8;
  localparam int LG    = $clog2(H_DECIM);
  localparam int SW    = 8 + LG;
  localparam int TOTAL = ACTIVE_COLS * ACTIVE_ROWS;
  localparam int HW    = (H_DECIM > 1) ? $clog2(H_DECIM) : 1;
  localparam int VW    = (V_DECIM > 1) ? $clog2(V_DECIM) : 1;
  localparam int FW    = (F_DECIM > 1) ? $clog2(F_DECIM) : 1;
  localparam int CW    = $clog2(ACTIVE_COLS + 1);
  localparam int RW    = $clog2(ACTIVE_ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_vs, r_vde;
  logic [FW-1:0]       r_fcnt;
  logic [VW-1:0]       r_vcnt;
  logic [HW-1:0]       r_hcnt;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [ADDR_W-1:0]   r_rowbase;
  logic [NCH*SW-1:0]   r_acc;
  logic [PIX_W-1:0]    r_first;
  logic                r_we_p1, r_done_p1, r_start_p1, r_err_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic [PIX_W-1:0]    r_data_p1;

  logic                w_vs, w_fb, w_le, w_ls, w_pix, w_kept, w_wr, w_last;
  logic                w_cap_start;
  logic [HW-1:0]       w_hcur;
  logic [ADDR_W-1:0]   w_addr;
  logic [NCH*SW-1:0]   w_sum;
  logic [PIX_W-1:0]    w_pix_out;
  logic                w_unused_hsync;

  // Mean of each channel's group sum; H_DECIM is a power of two, so a shift.
  function automatic logic [PIX_W-1:0] avg_trunc(input logic [NCH*SW-1:0] sums);
    logic [PIX_W-1:0] res;
    res = '0;
    for (int k = 0; k < NCH; k++) begin
      res[8*k +: 8] = 8'(sums[SW*k +: SW] >> LG);
    end
    return res;
  endfunction

  assign w_unused_hsync = i_hsync;

  // Stage p0: edge detection and write decision on the live input
  assign w_vs   = i_vsync ^ 1'(SYNC_ACTIVE_LOW);
  assign w_fb   = w_vs & ~r_vs;
  assign w_le   = ~i_vde & r_vde;
  assign w_ls   = i_vde & ~r_vde;
  // hcnt restarts on the first pixel of a line without waiting a cycle
  assign w_hcur = w_ls ? '0 : r_hcnt;
  // A frame boundary swallows a coincident pixel
  assign w_pix  = i_vde & ~w_fb;
  assign w_kept = (r_state == S_CAPTURE) && (r_vcnt == '0) &&
                  (r_row < RW'(ACTIVE_ROWS));
  assign w_wr   = w_kept && w_pix && (w_hcur == HW'(H_DECIM - 1)) &&
                  (r_col < CW'(ACTIVE_COLS));
  assign w_addr = r_rowbase + ADDR_W'(r_col);
  assign w_last = w_wr && (w_addr == ADDR_W'(TOTAL - 1));
  assign w_cap_start = w_fb && (r_fcnt == '0);

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sum[SW*k +: SW] = ((w_hcur == '0) ? SW'(0) : r_acc[SW*k +: SW]) +
                          SW'(i_data[8*k +: 8]);
    end
  end

  assign w_pix_out = (AVG_MODE != 0) ? avg_trunc(w_sum) :
                     ((w_hcur == '0) ? i_data : r_first);

  always_comb begin
    w_state_nxt = r_state;
    if (w_fb) begin
      w_state_nxt = (r_fcnt == '0) ? S_CAPTURE : S_SKIP;
    end else if ((r_state == S_CAPTURE) && w_last) begin
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_vs       <= 1'b0;
      r_vde      <= 1'b0;
      r_fcnt     <= '0;
      r_vcnt     <= '0;
      r_hcnt     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_rowbase  <= '0;
      r_start_p1 <= 1'b0;
      r_err_p1   <= 1'b0;
      r_done_p1  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vs       <= w_vs;
      r_vde      <= i_vde;
      r_start_p1 <= w_cap_start;
      r_err_p1   <= w_fb && (r_state == S_CAPTURE);
      r_done_p1  <= w_last;

      if (w_fb) begin
        r_fcnt <= (r_fcnt == FW'(F_DECIM - 1)) ? '0 : r_fcnt + FW'(1);
      end

      if (w_fb) begin
        r_vcnt <= '0;
      end else if (w_le) begin
        r_vcnt <= (r_vcnt == VW'(V_DECIM - 1)) ? '0 : r_vcnt + VW'(1);
      end

      if (i_vde) begin
        if (w_fb) begin
          r_hcnt <= w_hcur;
        end else begin
          r_hcnt <= (w_hcur == HW'(H_DECIM - 1)) ? '0 : w_hcur + HW'(1);
        end
      end

      if (w_cap_start) begin
        r_col     <= '0;
        r_row     <= '0;
        r_rowbase <= '0;
      end else if (r_state == S_CAPTURE) begin
        if (w_le && (r_vcnt == '0) && (r_row < RW'(ACTIVE_ROWS))) begin
          r_row     <= r_row + RW'(1);
          r_rowbase <= r_rowbase + ADDR_W'(ACTIVE_COLS);
          r_col     <= '0;
        end else if (w_wr) begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (w_cap_start) begin
      r_acc <= '0;
    end else if (w_pix) begin
      r_acc <= w_sum;
      if (w_hcur == '0) begin
        r_first <= i_data;
      end
    end
  end

  // Stage p1: registered BRAM write port
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else begin
      r_we_p1 <= w_wr;
      if (w_wr) begin
        r_addr_p1 <= w_addr;
        r_data_p1 <= w_pix_out;
      end
    end
  end

  assign o_we          = r_we_p1;
  assign o_addr        = r_addr_p1;
  assign o_data        = r_data_p1;
  assign o_start_frame = r_start_p1;
  assign o_frame_done  = r_done_p1;
  assign o_frame_err   = r_err_p1;

endmodule

// File: tb/tb_video_decim2bram.sv
// Testbench for video_decim2bram: two instances (first-pixel and averaging)
// share one stimulus stream; a scoreboard queue holds the expected writes.
module tb_video_decim2bram;

  localparam int PW = 24;
  localparam int AW = 16;

  logic          pclk = 1'b0;
  logic          rst  = 1'b1;
  logic          i_hsync = 1'b0;
  logic          i_vsync = 1'b1;
  logic          i_vde   = 1'b0;
  logic [PW-1:0] i_data  = '0;

  logic          we0, sf0, fd0, fe0, we1, sf1, fd1, fe1;
  logic [AW-1:0] addr0, addr1;
  logic [PW-1:0] data0, data1;

  always #5 pclk = ~pclk;

  video_decim2bram #(.PIX_W(24), .ACTIVE_COLS(4), .ACTIVE_ROWS(2), .H_DECIM(2),
    .V_DECIM(2), .F_DECIM(3), .ADDR_W(16), .SYNC_ACTIVE_LOW(1), .AVG_MODE(0)) dut0 (
    .pclk(pclk), .rst(rst), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_vde(i_vde),
    .i_data(i_data), .o_we(we0), .o_addr(addr0), .o_data(data0),
    .o_start_frame(sf0), .o_frame_done(fd0), .o_frame_err(fe0));

  video_decim2bram #(.PIX_W(24), .ACTIVE_COLS(4), .ACTIVE_ROWS(2), .H_DECIM(2),
    .V_DECIM(2), .F_DECIM(3), .ADDR_W(16), .SYNC_ACTIVE_LOW(1), .AVG_MODE(1)) dut1 (
    .pclk(pclk), .rst(rst), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_vde(i_vde),
    .i_data(i_data), .o_we(we1), .o_addr(addr1), .o_data(data1),
    .o_start_frame(sf1), .o_frame_done(fd1), .o_frame_err(fe1));

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] d0;
    logic [PW-1:0] d1;
    logic          done;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr = 0, n_start0 = 0, n_start1 = 0, n_done0 = 0, n_done1 = 0;
  int   n_err0 = 0, n_err1 = 0;
  int   tb_fcnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rval(input int col, input int seed);
    if (seed == 0) return 8'h00;
    return 8'(10 * (col + 1) + ((col % 4 == 3) ? 1 : 0));
  endfunction

  function automatic logic [PW-1:0] pix(input int line, input int col, input int seed);
    return {8'(line), 8'(col), rval(col, seed)};
  endfunction

  function automatic logic [PW-1:0] avg2(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    for (int k = 0; k < 3; k++) begin
      r[8*k +: 8] = 8'((9'(a[8*k +: 8]) + 9'(b[8*k +: 8])) >> 1);
    end
    return r;
  endfunction

  // Monitor: sample one time unit after the active edge
  always @(posedge pclk) begin
    exp_t e;
    #1;
    if (we0 === 1'b1 || we1 === 1'b1) begin
      n_wr++;
      if (q.size() == 0) begin
        check("unexpected_we", 32'(we0), 32'(0));
      end else begin
        e = q.pop_front();
        check("we1", 32'(we1), 32'(1));
        check("addr0", 32'(addr0), 32'(e.addr));
        check("data0", 32'(data0), 32'(e.d0));
        check("done0", 32'(fd0), 32'(e.done));
        check("addr1", 32'(addr1), 32'(e.addr));
        check("data1", 32'(data1), 32'(e.d1));
        check("done1", 32'(fd1), 32'(e.done));
      end
    end else if (fd0 === 1'b1 || fd1 === 1'b1) begin
      check("done_without_we", 32'(fd0 | fd1), 32'(0));
    end
    if (sf0 === 1'b1) n_start0++;
    if (sf1 === 1'b1) n_start1++;
    if (fd0 === 1'b1) n_done0++;
    if (fd1 === 1'b1) n_done1++;
    if (fe0 === 1'b1) n_err0++;
    if (fe1 === 1'b1) n_err1++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      i_vde = 1'b0;
    end
  endtask

  // One frame: vsync pulse then nlines lines; line 2 uses npix_b pixels.
  task automatic drive_frame(input int nlines, input int npix_a, input int npix_b, input int seed);
    bit cap;
    int row, npix, ng;
    exp_t e;
    cap = (tb_fcnt == 0);
    tb_fcnt = (tb_fcnt + 1) % 3;
    row = 0;
    @(negedge pclk); i_vsync = 1'b0;
    @(negedge pclk);
    @(negedge pclk); i_vsync = 1'b1;
    idle(3);
    for (int l = 0; l < nlines; l++) begin
      npix = (l == 2) ? npix_b : npix_a;
      if (cap && (l % 2 == 0) && row < 2) begin
        ng = npix / 2;
        if (ng > 4) ng = 4;
        for (int g = 0; g < ng; g++) begin
          e.addr = 16'(row * 4 + g);
          e.d0   = pix(l, 2 * g, seed);
          e.d1   = avg2(pix(l, 2 * g, seed), pix(l, 2 * g + 1, seed));
          e.done = (row * 4 + g == 7);
          q.push_back(e);
        end
        row++;
      end
      for (int p = 0; p < npix; p++) begin
        @(negedge pclk);
        i_vde  = 1'b1;
        i_data = pix(l, p, seed);
      end
      idle(4);
    end
    idle(3);
  endtask

  task automatic check_counts(input string tag, input int wr, input int st, input int dn, input int er);
    check({tag, "_wr"}, 32'(n_wr), 32'(wr));
    check({tag, "_start0"}, 32'(n_start0), 32'(st));
    check({tag, "_start1"}, 32'(n_start1), 32'(st));
    check({tag, "_done0"}, 32'(n_done0), 32'(dn));
    check({tag, "_done1"}, 32'(n_done1), 32'(dn));
    check({tag, "_err0"}, 32'(n_err0), 32'(er));
    check({tag, "_err1"}, 32'(n_err1), 32'(er));
    check({tag, "_qempty"}, 32'(q.size()), 32'(0));
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    check("rst_we", 32'({we0, we1}), 32'(0));
    check("rst_addr", 32'(addr0 | addr1), 32'(0));
    check("rst_data", 32'(data0 | data1), 32'(0));
    check("rst_pulses", 32'({sf0, fd0, fe0, sf1, fd1, fe1}), 32'(0));
    rst = 1'b0;
    idle(4);

    drive_frame(4, 8, 8, 0);                 // captured
    check_counts("f1", 8, 1, 1, 0);
    drive_frame(4, 8, 8, 0);                 // skipped
    drive_frame(4, 8, 8, 0);                 // skipped
    check_counts("f3", 8, 1, 1, 0);
    drive_frame(4, 8, 8, 1);                 // captured, averaging pattern
    check_counts("f4", 16, 2, 2, 0);

    drive_frame(4, 8, 8, 1);                 // skipped
    drive_frame(4, 8, 8, 1);                 // skipped
    drive_frame(2, 8, 8, 1);                 // captured, cut short
    drive_frame(4, 8, 8, 0);                 // error pulse, skipped
    check_counts("f8", 20, 3, 2, 1);
    drive_frame(4, 8, 8, 0);                 // skipped

    drive_frame(4, 12, 7, 1);                // 4 + 3 writes
    check_counts("f10", 27, 4, 2, 1);
    drive_frame(4, 8, 8, 0);                 // error pulse, skipped
    drive_frame(4, 8, 8, 0);                 // skipped
    check_counts("f12", 27, 4, 2, 2);

    drive_frame(1, 8, 8, 0);                 // captured, addr 0..3 then reset
    @(negedge pclk); rst = 1'b1;
    @(posedge pclk); #1;
    check("rst_mid_we", 32'({we0, we1}), 32'(0));
    check("rst_mid_pulses", 32'({sf0, fd0, fe0, sf1, fd1, fe1}), 32'(0));
    @(negedge pclk); rst = 1'b0;
    tb_fcnt = 0;
    idle(4);
    check_counts("f13", 31, 5, 2, 2);
    drive_frame(4, 8, 8, 1);                 // captured from addr 0
    check_counts("f14", 39, 6, 3, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
